// File: rtl/constants_pkg.sv
// ============================================================================
// constants_pkg : architectural widths and load/store func3 encodings.
// Rev 1.0
// ============================================================================
`default_nettype none

package constants_pkg;

    localparam int ARCH_LEN = 32;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Access width from func3; any encoding not defined for the access kind is a word.
    function automatic logic [1:0] ls_size(input logic [2:0] func3, input logic is_store);
        logic [1:0] size;
        size = SZ_W;
        case (func3)
            LS_B:  size = SZ_B;
            LS_H:  size = SZ_H;
            LS_BU: size = is_store ? SZ_W : SZ_B;
            LS_HU: size = is_store ? SZ_W : SZ_H;
            default: size = SZ_W;
        endcase
        return size;
    endfunction

endpackage

`default_nettype wire

// File: rtl/structure_pkg.sv
// ============================================================================
// structure_pkg : pipeline instruction record and memory-stage state type.
// Rev 1.0
// ============================================================================
`default_nettype none

package structure_pkg;
    import constants_pkg::*;

    typedef enum logic [1:0] {
        MEM_IDLE     = 2'd0,
        MEM_REQ      = 2'd1,
        MEM_WAIT_RSP = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [ARCH_LEN-1:0] src_data_1;
        logic [ARCH_LEN-1:0] src_data_2;
        logic [ARCH_LEN-1:0] dst_reg_data;
        logic [4:0]          rd;
        logic [2:0]          func3;
        logic                is_load;
        logic                is_store;
        logic                reg_data_ready;
    } inst_decoded_t;

endpackage

`default_nettype wire

// File: rtl/mem_load_extend.sv
// ============================================================================
// mem_load_extend : aligns a loaded word by byte offset and sign/zero extends.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_load_extend
    import constants_pkg::*;
(
    input  logic [ARCH_LEN-1:0] rdata,
    input  logic [1:0]          addr,
    input  logic [2:0]          func3,
    output logic [ARCH_LEN-1:0] data
);

    logic [ARCH_LEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        case (func3)
            LS_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            LS_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            LS_BU:   data = {24'd0, shifted[7:0]};
            LS_HU:   data = {16'd0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : pipeline memory-access stage with valid/ready data-memory port.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import constants_pkg::*;
    import structure_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  inst_decoded_t       inst_mem_in,
    input  logic                in_valid,
    output logic                stall,
    output inst_decoded_t       inst_mem_out,
    output logic                out_valid,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic                dmem_req_we,
    output logic [ARCH_LEN-1:0] dmem_req_addr,
    output logic [ARCH_LEN-1:0] dmem_req_wdata,
    output logic [3:0]          dmem_req_be,
    input  logic                dmem_rsp_valid,
    input  logic [ARCH_LEN-1:0] dmem_rsp_rdata,
    output logic                misalign_fault
);

    mem_state_t          state;
    inst_decoded_t       held;
    logic [1:0]          off;
    logic [1:0]          acc_size;
    logic [3:0]          be_next;
    logic [ARCH_LEN-1:0] wdata_next;
    logic [ARCH_LEN-1:0] load_word;
    logic                misaligned;

    assign stall = (state != MEM_IDLE);

    always_comb begin
        off      = inst_mem_in.dst_reg_data[1:0];
        acc_size = ls_size(inst_mem_in.func3, inst_mem_in.is_store);
        case (acc_size)
            SZ_B: begin
                be_next    = 4'(4'b0001 << off);
                wdata_next = {4{inst_mem_in.src_data_2[7:0]}};
            end
            SZ_H: begin
                be_next    = 4'(4'b0011 << off);
                wdata_next = {2{inst_mem_in.src_data_2[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = inst_mem_in.src_data_2;
            end
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = ((acc_size == SZ_H) && off[0]) || ((acc_size == SZ_W) && (off != 2'd0));
`else
        misaligned = 1'b0;
`endif
    end

    mem_load_extend u_load_extend (
        .rdata (dmem_rsp_rdata),
        .addr  (held.dst_reg_data[1:0]),
        .func3 (held.func3),
        .data  (load_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= MEM_IDLE;
            held           <= '0;
            inst_mem_out   <= '0;
            out_valid      <= 1'b0;
            dmem_req_valid <= 1'b0;
            dmem_req_we    <= 1'b0;
            dmem_req_addr  <= '0;
            dmem_req_wdata <= '0;
            dmem_req_be    <= 4'd0;
            misalign_fault <= 1'b0;
        end else begin
            out_valid      <= 1'b0;
            misalign_fault <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (in_valid) begin
                        if (!(inst_mem_in.is_load || inst_mem_in.is_store)) begin
                            inst_mem_out <= inst_mem_in;
                            out_valid    <= 1'b1;
                        end else if (misaligned) begin
                            // Trapped access retires without touching memory.
                            inst_mem_out                <= inst_mem_in;
                            inst_mem_out.reg_data_ready <= 1'b0;
                            out_valid                   <= 1'b1;
                            misalign_fault              <= 1'b1;
                        end else begin
                            held           <= inst_mem_in;
                            dmem_req_valid <= 1'b1;
                            dmem_req_we    <= inst_mem_in.is_store;
                            dmem_req_addr  <= {inst_mem_in.dst_reg_data[ARCH_LEN-1:2], 2'b00};
                            dmem_req_wdata <= wdata_next;
                            dmem_req_be    <= be_next;
                            state          <= MEM_REQ;
                        end
                    end
                end
                MEM_REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        if (held.is_store) begin
                            inst_mem_out                <= held;
                            inst_mem_out.reg_data_ready <= 1'b0;
                            out_valid                   <= 1'b1;
                            state                       <= MEM_IDLE;
                        end else begin
                            state <= MEM_WAIT_RSP;
                        end
                    end
                end
                MEM_WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        inst_mem_out                <= held;
                        inst_mem_out.dst_reg_data   <= load_word;
                        inst_mem_out.reg_data_ready <= 1'b1;
                        out_valid                   <= 1'b1;
                        state                       <= MEM_IDLE;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed self-checking bench for mem_stage.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;
    import constants_pkg::*;
    import structure_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    inst_decoded_t inst_mem_in;
    logic          in_valid = 1'b0;
    logic          stall;
    inst_decoded_t inst_mem_out;
    logic          out_valid;
    logic          dmem_req_valid;
    logic          dmem_req_ready = 1'b0;
    logic          dmem_req_we;
    logic [31:0]   dmem_req_addr;
    logic [31:0]   dmem_req_wdata;
    logic [3:0]    dmem_req_be;
    logic          dmem_rsp_valid = 1'b0;
    logic [31:0]   dmem_rsp_rdata = 32'd0;
    logic          misalign_fault;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .inst_mem_in    (inst_mem_in),
        .in_valid       (in_valid),
        .stall          (stall),
        .inst_mem_out   (inst_mem_out),
        .out_valid      (out_valid),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_req_be    (dmem_req_be),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .misalign_fault (misalign_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        inst_mem_in              = '0;
        inst_mem_in.is_load      = ld;
        inst_mem_in.is_store     = st;
        inst_mem_in.func3        = f3;
        inst_mem_in.dst_reg_data = addr;
        inst_mem_in.src_data_2   = data;
        in_valid                 = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        issue(1'b0, 1'b1, f3, addr, data);
        dmem_req_ready = 1'b1;
        chk({tag, ".req_valid"}, dmem_req_valid, 1);
        chk({tag, ".we"}, dmem_req_we, 1);
        chk({tag, ".addr"}, dmem_req_addr, exp_addr);
        chk({tag, ".be"}, dmem_req_be, exp_be);
        chk({tag, ".wdata"}, dmem_req_wdata, exp_wdata);
        tick();
        dmem_req_ready = 1'b0;
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".rdr"}, inst_mem_out.reg_data_ready, 0);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data);
        issue(1'b1, 1'b0, f3, addr, 32'd0);
        dmem_req_ready = 1'b1;
        chk({tag, ".req_valid"}, dmem_req_valid, 1);
        chk({tag, ".we"}, dmem_req_we, 0);
        chk({tag, ".addr"}, dmem_req_addr, exp_addr);
        tick();
        dmem_req_ready = 1'b0;
        chk({tag, ".stall_wait"}, stall, 1);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = rdata;
        tick();
        dmem_rsp_valid = 1'b0;
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".data"}, inst_mem_out.dst_reg_data, exp_data);
        chk({tag, ".rdr"}, inst_mem_out.reg_data_ready, 1);
        chk({tag, ".stall_done"}, stall, 0);
    endtask

    initial begin
        inst_mem_in = '0;
        #3;
        chk("rst.stall", stall, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.req_valid", dmem_req_valid, 0);
        chk("rst.we", dmem_req_we, 0);
        chk("rst.addr", dmem_req_addr, 0);
        chk("rst.wdata", dmem_req_wdata, 0);
        chk("rst.be", dmem_req_be, 0);
        chk("rst.fault", misalign_fault, 0);
        chk("rst.out_lo", inst_mem_out[31:0], 0);
        chk("rst.out_dst", inst_mem_out.dst_reg_data, 0);
        tick();
        rst = 1'b0;
        tick();

        // Non-memory instruction: one cycle latency, no stall
        inst_mem_in                = '0;
        inst_mem_in.dst_reg_data   = 32'h1234;
        inst_mem_in.reg_data_ready = 1'b1;
        in_valid                   = 1'b1;
        chk("add.stall_in", stall, 0);
        tick();
        in_valid = 1'b0;
        chk("add.out_valid", out_valid, 1);
        chk("add.dst", inst_mem_out.dst_reg_data, 32'h1234);
        chk("add.stall", stall, 0);
        tick();
        chk("add.out_pulse", out_valid, 0);

        // SB with ready held low for three cycles
        issue(1'b0, 1'b1, LS_B, 32'h103, 32'hAB);
        for (int i = 0; i < 3; i++) begin
            chk("sb.req_valid", dmem_req_valid, 1);
            chk("sb.addr", dmem_req_addr, 32'h100);
            chk("sb.be", dmem_req_be, 4'b1000);
            chk("sb.wdata", dmem_req_wdata, 32'hABABABAB);
            chk("sb.stall", stall, 1);
            chk("sb.no_out", out_valid, 0);
            tick();
        end
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        chk("sb.out_valid", out_valid, 1);
        chk("sb.req_drop", dmem_req_valid, 0);
        chk("sb.stall_done", stall, 0);

        do_store("sh", LS_H, 32'h3, 32'h5555_1234, 32'h0, 4'b1000, 32'h12341234);
        do_store("sw", LS_W, 32'h10, 32'hCAFEBABE, 32'h10, 4'b1111, 32'hCAFEBABE);
        do_store("sh2", LS_H, 32'h22, 32'hBEEF, 32'h20, 4'b1100, 32'hBEEFBEEF);

        do_load("lb", LS_B, 32'h202, 32'h0080_0000, 32'h200, 32'hFFFFFF80);
        do_load("lbu", LS_BU, 32'h202, 32'h0080_0000, 32'h200, 32'h00000080);
        do_load("lhu", LS_HU, 32'h302, 32'h9876_0000, 32'h300, 32'h00009876);
        do_load("lw", LS_W, 32'h40, 32'h89AB_CDEF, 32'h40, 32'h89ABCDEF);
        tick();

        // Spurious response while idle, then LH with a five-cycle response delay
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_rsp_valid = 1'b0;
        chk("spur.out_valid", out_valid, 0);
        chk("spur.stall", stall, 0);
        issue(1'b1, 1'b0, LS_H, 32'h0, 32'd0);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("lh.wait_out", out_valid, 0);
            chk("lh.wait_stall", stall, 1);
            tick();
        end
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h1234_8001;
        tick();
        dmem_rsp_valid = 1'b0;
        chk("lh.out_valid", out_valid, 1);
        chk("lh.data", inst_mem_out.dst_reg_data, 32'hFFFF8001);
        tick();
        chk("lh.out_pulse", out_valid, 0);

        // Reset while a request is pending
        issue(1'b1, 1'b0, LS_W, 32'h80, 32'd0);
        chk("rreq.req_valid", dmem_req_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rreq.req_valid_rst", dmem_req_valid, 0);
        chk("rreq.stall_rst", stall, 0);
        chk("rreq.addr_rst", dmem_req_addr, 0);
        tick();
        rst = 1'b0;
        tick();

        // Reset while awaiting a load response, then a late response arrives
        issue(1'b1, 1'b0, LS_W, 32'h84, 32'd0);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        chk("rwait.stall", stall, 1);
        #2 rst = 1'b1;
        #1;
        chk("rwait.stall_rst", stall, 0);
        chk("rwait.req_valid_rst", dmem_req_valid, 0);
        chk("rwait.out_valid_rst", out_valid, 0);
        tick();
        rst = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h5A5A_5A5A;
        tick();
        dmem_rsp_valid = 1'b0;
        chk("rwait.late_out", out_valid, 0);
        chk("rwait.late_stall", stall, 0);
        chk("rwait.late_dst", inst_mem_out.dst_reg_data, 0);

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned LW traps without a memory request
        inst_mem_in              = '0;
        inst_mem_in.is_load      = 1'b1;
        inst_mem_in.func3        = LS_W;
        inst_mem_in.dst_reg_data = 32'h102;
        in_valid                 = 1'b1;
        #1;
        chk("mis.req_in", dmem_req_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("mis.req_valid", dmem_req_valid, 0);
        chk("mis.out_valid", out_valid, 1);
        chk("mis.fault", misalign_fault, 1);
        chk("mis.rdr", inst_mem_out.reg_data_ready, 0);
        chk("mis.stall", stall, 0);
        tick();
        chk("mis.fault_pulse", misalign_fault, 0);
`else
        // Without the trap, a misaligned LW uses the zero-filled shifted word
        do_load("mislw", LS_W, 32'h102, 32'hAABB_CCDD, 32'h100, 32'h0000AABB);
        chk("mislw.fault", misalign_fault, 0);
        chk("mislw.be", dmem_req_be, 4'b1111);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
